bdc_motor_root: RTL and testbench

//  Top of a 3-channel brushed-DC motor controller driven by an SPI slave.
//  - Per channel: 8-bit PWM, 2-bit H-bridge outputs, quadrature tach counter, config register.
//  - Global: watchdog and a constant hardware-ID register.

---
 rtl/bdc_motor_pkg.sv | 37 +++
 rtl/bdc_motor_if.sv | 14 +
 rtl/bdc_motor_channel.sv | 110 +++++++++++
 rtl/bdc_motor_root.sv | 224 ++++++++++++++++++++++
 tb/tb_bdc_motor_root.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bdc_motor_pkg.sv
// Shared definitions for the 3-channel brushed-DC motor controller.
// Holds register address constants, control-register bit positions, SPI frame
// widths, the SPI slave state type and a quadrature Gray-to-binary helper.
package bdc_motor_pkg;

  localparam int unsigned NumCh     = 3;
  localparam int unsigned FrameBits = 16;
  localparam int unsigned CmdBits   = 8;

  // Global register addresses; channel n occupies 4n..4n+3.
  localparam logic [3:0] AddrZero  = 4'hC;
  localparam logic [3:0] AddrHwCfg = 4'hD;
  localparam logic [3:0] AddrWdiv  = 4'hE;
  localparam logic [3:0] AddrCtrl  = 4'hF;

  // Offsets inside a channel block.
  localparam logic [1:0] OffTach   = 2'd0;
  localparam logic [1:0] OffShadow = 2'd1;
  localparam logic [1:0] OffCfg    = 2'd2;
  localparam logic [1:0] OffStatus = 2'd3;

  // Control register (0xF) bit positions.
  localparam int unsigned CtrlMotorEnBit = 3;
  localparam int unsigned CtrlTripBit    = 7;

  typedef enum logic [1:0] {
    StCmd,
    StData,
    StDone
  } spi_st_e;

  // Quadrature phase index: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/bdc_motor_if.sv
// SPI bus between a master and the motor controller.
//   sclk : serial clock, idles high
//   ss   : active-high slave select
//   mosi : master-to-slave data, MSB first
// miso stays a plain tri-state port on the controller so the Z drive lives
// at the device boundary.
interface bdc_motor_if;
  logic sclk;
  logic ss;
  logic mosi;

  modport master (output sclk, output ss, output mosi);
  modport slave  (input sclk, input ss, input mosi);
endinterface

// File: rtl/bdc_motor_channel.sv
// One motor channel: double-buffered PWM duty, config register, quadrature
// tach counter with read shadow, optional current-limit blanking, and bridge
// output gating.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   pwm_cnt, pwm_wrap    shared PWM counter and its last-count flag
//   motorena, en         global and per-channel enables
//   wr_duty, wr_cfg      write strobes for duty / config with wdata
//   snap                 capture tach[15:8] into the shadow (read of +0)
//   rd_off, rdata        register read offset and data
//   tach, currentlimit   raw asynchronous inputs (synchronised here)
//   pwm                  [0]=forward, [1]=reverse
// Option macro: CURRENT_LIMIT_EN enables current-limit blanking and status.
module bdc_motor_channel
  import bdc_motor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pwm_cnt,
  input  logic       pwm_wrap,
  input  logic       motorena,
  input  logic       en,
  input  logic       wr_duty,
  input  logic       wr_cfg,
  input  logic [7:0] wdata,
  input  logic       snap,
  input  logic [1:0] rd_off,
  output logic [7:0] rdata,
  input  logic [1:0] tach,
  input  logic       currentlimit,
  output logic [1:0] pwm
);

  logic [1:0]  tach_s1_q, tach_s2_q, tach_prev_q;
  logic [7:0]  duty_buf_q, duty_q, cfg_q, shadow_q;
  logic [15:0] count_q;
  logic [1:0]  step;
  logic        climit;
  logic        active;

  // Phase difference modulo 4: +1 forward, 3 reverse, 2 is an illegal jump.
  assign step = gray2bin(tach_s2_q) - gray2bin(tach_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tach_s1_q   <= '0;
      tach_s2_q   <= '0;
      tach_prev_q <= '0;
      duty_buf_q  <= '0;
      duty_q      <= '0;
      cfg_q       <= '0;
      shadow_q    <= '0;
      count_q     <= '0;
    end else begin
      tach_s1_q   <= tach;
      tach_s2_q   <= tach_s1_q;
      tach_prev_q <= tach_s2_q;
      if (wr_duty) duty_buf_q <= wdata;
      if (pwm_wrap) duty_q <= duty_buf_q;
      if (wr_cfg) cfg_q <= wdata;
      // Snapshot sees the pre-increment count of the same cycle.
      if (snap) shadow_q <= count_q[15:8];
      case (step)
        2'd1:    count_q <= count_q + 16'd1;
        2'd3:    count_q <= count_q - 16'd1;
        default: ;
      endcase
    end
  end

`ifdef CURRENT_LIMIT_EN
  logic cl_s1_q, cl_s2_q, climit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl_s1_q  <= 1'b0;
      cl_s2_q  <= 1'b0;
      climit_q <= 1'b0;
    end else begin
      cl_s1_q <= currentlimit;
      cl_s2_q <= cl_s1_q;
      if (pwm_wrap) begin
        climit_q <= 1'b0;
      end else if (cl_s2_q) begin
        climit_q <= 1'b1;
      end
    end
  end

  assign climit = climit_q;
`else
  logic unused_currentlimit;
  assign unused_currentlimit = currentlimit;
  assign climit = 1'b0;
`endif

  assign active = (pwm_cnt < duty_q) & en & motorena & ~climit;
  assign pwm    = cfg_q[0] ? {active, 1'b0} : {1'b0, active};

  always_comb begin
    rdata = '0;
    case (rd_off)
      OffTach:   rdata = count_q[7:0];
      OffShadow: rdata = shadow_q;
      OffCfg:    rdata = cfg_q;
      default:   rdata = {7'b0, climit};
    endcase
  end

endmodule

// File: rtl/bdc_motor_root.sv
// Top of the 3-channel brushed-DC motor controller with SPI slave register
// access, shared PWM counter, watchdog and hardware-ID register.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   spi                   SPI slave (sclk, ss, mosi)
//   miso                  SPI data out, Z while ss is low
//   tstn                  0 selects the short watchdog prescaler
//   wdogdisn              0 disables (and clears) the watchdog
//   currentlimit0..2      per-channel over-current flags
//   tach0..2              quadrature inputs {B,A}
//   motorena              global driver enable
//   pwm0..2               bridge drive, [0]=forward [1]=reverse
// Option macro: CURRENT_LIMIT_EN (see bdc_motor_channel).
module bdc_motor_root
  import bdc_motor_pkg::*;
#(
  parameter logic [7:0]  HW_CONFIG    = 8'h30,
  parameter int unsigned WDOG_PS_LOG2 = 16,
  parameter int unsigned TEST_PS_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  bdc_motor_if.slave spi,
  output logic       miso,
  input  logic       tstn,
  input  logic       wdogdisn,
  input  logic       currentlimit0,
  input  logic       currentlimit1,
  input  logic       currentlimit2,
  input  logic [1:0] tach0,
  input  logic [1:0] tach1,
  input  logic [1:0] tach2,
  output logic       motorena,
  output logic [1:0] pwm0,
  output logic [1:0] pwm1,
  output logic [1:0] pwm2
);

  localparam int unsigned PsW = (WDOG_PS_LOG2 > TEST_PS_LOG2) ? WDOG_PS_LOG2 : TEST_PS_LOG2;
  localparam logic [PsW-1:0] PsMaskNorm = PsW'((64'd1 << WDOG_PS_LOG2) - 64'd1);
  localparam logic [PsW-1:0] PsMaskTest = PsW'((64'd1 << TEST_PS_LOG2) - 64'd1);

  // SPI input synchronisers; sclk has a third stage for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q, ss_s1_q, ss_s2_q, mosi_s1_q, mosi_s2_q;
  logic sclk_rise;

  spi_st_e    st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [4:0] cmd_q, cmd_d;       // {rw, addr}
  logic [7:0] wdata_q, wdata_d;
  logic       wr_pend_q, wr_pend_d;
  logic [7:0] byte_in;
  logic [3:0] rd_addr, waddr;
  logic [7:0] rd_val;
  logic       snap;

  logic [7:0] pwm_cnt_q, wdiv_q, wcnt_q;
  logic [3:0] ctrl_q;
  logic       trip_q, trip_d;
  logic [PsW-1:0] ps_q, ps_mask;
  logic       wd_run, tick, pwm_wrap;

  logic [7:0] ch_rdata [NumCh];
  logic [1:0] ch_tach  [NumCh];
  logic [1:0] ch_pwm   [NumCh];
  logic [NumCh-1:0] ch_cl;

  assign ch_tach[0] = tach0;
  assign ch_tach[1] = tach1;
  assign ch_tach[2] = tach2;
  assign ch_cl      = {currentlimit2, currentlimit1, currentlimit0};
  assign pwm0       = ch_pwm[0];
  assign pwm1       = ch_pwm[1];
  assign pwm2       = ch_pwm[2];

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q & ss_s2_q;
  assign byte_in   = {rx_q, mosi_s2_q};
  // At the 8th rise rx_q holds command bits 7..1, so rw/addr are already known.
  assign rd_addr   = rx_q[5:2];
  assign waddr     = cmd_q[3:0];
  assign miso      = spi.ss ? tx_q[7] : 1'bz;

  always_comb begin
    rd_val = '0;
    case (rd_addr[3:2])
      2'd0: rd_val = ch_rdata[0];
      2'd1: rd_val = ch_rdata[1];
      2'd2: rd_val = ch_rdata[2];
      default: begin
        case (rd_addr)
          AddrHwCfg: rd_val = HW_CONFIG;
          AddrWdiv:  rd_val = wdiv_q;
          AddrCtrl:  rd_val = {trip_q, 3'b000, ctrl_q};
          default:   rd_val = '0;
        endcase
      end
    endcase
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    wdata_d   = wdata_q;
    wr_pend_d = 1'b0;
    snap      = 1'b0;
    if (!ss_s2_q) begin
      st_d  = StCmd;
      cnt_d = '0;
      tx_d  = '0;
    end else if (sclk_rise) begin
      rx_d  = byte_in[6:0];
      cnt_d = cnt_q + 3'd1;
      unique case (st_q)
        StCmd: begin
          if (cnt_q == 3'd7) begin
            st_d  = StData;
            cmd_d = byte_in[7:3];
            tx_d  = rd_val;
            snap  = rx_q[6] && (rd_addr[1:0] == OffTach);
          end
        end
        StData: begin
          tx_d = {tx_q[6:0], 1'b0};
          if (cnt_q == 3'd7) begin
            st_d      = StDone;
            wdata_d   = byte_in;
            wr_pend_d = ~cmd_q[4];
          end
        end
        default: tx_d = {tx_q[6:0], 1'b0};
      endcase
    end
  end

  assign ps_mask  = tstn ? PsMaskNorm : PsMaskTest;
  assign wd_run   = ctrl_q[CtrlMotorEnBit] & ~trip_q & wdogdisn;
  assign tick     = wd_run && ((ps_q & ps_mask) == ps_mask);
  assign pwm_wrap = (pwm_cnt_q == 8'hFF);
  assign motorena = ctrl_q[CtrlMotorEnBit] & ~trip_q;

  always_comb begin
    trip_d = trip_q;
    if (wr_pend_q && (waddr == AddrCtrl) && wdata_q[CtrlTripBit]) trip_d = 1'b0;
    // A trip in the same cycle as the clearing write wins.
    if (tick && (wcnt_q == wdiv_q)) trip_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ss_s1_q   <= 1'b0;
      ss_s2_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      st_q      <= StCmd;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      wdata_q   <= '0;
      wr_pend_q <= 1'b0;
      pwm_cnt_q <= '0;
      wdiv_q    <= '0;
      ctrl_q    <= '0;
      trip_q    <= 1'b0;
      ps_q      <= '0;
      wcnt_q    <= '0;
    end else begin
      sclk_s1_q <= spi.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= spi.ss;
      ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= spi.mosi;
      mosi_s2_q <= mosi_s1_q;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      wdata_q   <= wdata_d;
      wr_pend_q <= wr_pend_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      trip_q    <= trip_d;
      if (wr_pend_q && (waddr == AddrWdiv)) wdiv_q <= wdata_q;
      if (wr_pend_q && (waddr == AddrCtrl)) ctrl_q <= wdata_q[3:0];
      if (!wd_run || wr_pend_q) begin
        ps_q   <= '0;
        wcnt_q <= '0;
      end else begin
        ps_q <= ps_q + 1'b1;
        if (tick) wcnt_q <= wcnt_q + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    bdc_motor_channel u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_cnt      (pwm_cnt_q),
      .pwm_wrap     (pwm_wrap),
      .motorena     (motorena),
      .en           (ctrl_q[i]),
      .wr_duty      (wr_pend_q && (waddr == 4'(4 * i))),
      .wr_cfg       (wr_pend_q && (waddr == 4'(4 * i + 2))),
      .wdata        (wdata_q),
      .snap         (snap && (rd_addr[3:2] == 2'(i))),
      .rd_off       (rd_addr[1:0]),
      .rdata        (ch_rdata[i]),
      .tach         (ch_tach[i]),
      .currentlimit (ch_cl[i]),
      .pwm          (ch_pwm[i])
    );
  end

endmodule

// File: tb/tb_bdc_motor_root.sv
// Self-checking bench for bdc_motor_root: SPI register access, watchdog,
// quadrature tach counting, PWM duty/direction and frame abort handling.
module tb_bdc_motor_root;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tstn, wdogdisn;
  logic       currentlimit0, currentlimit1, currentlimit2;
  logic [1:0] tach0, tach1, tach2;
  logic       motorena;
  logic [1:0] pwm0, pwm1, pwm2;
  wire        miso;

  int passed = 0;
  int total  = 0;

  logic [7:0]  cfg_model  [3];
  logic [15:0] tach_model [3];
  logic [1:0]  tach_pos   [3];

  bdc_motor_if spi ();

  bdc_motor_root dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (spi),
    .miso          (miso),
    .tstn          (tstn),
    .wdogdisn      (wdogdisn),
    .currentlimit0 (currentlimit0),
    .currentlimit1 (currentlimit1),
    .currentlimit2 (currentlimit2),
    .tach0         (tach0),
    .tach1         (tach1),
    .tach2         (tach2),
    .motorena      (motorena),
    .pwm0          (pwm0),
    .pwm1          (pwm1),
    .pwm2          (pwm2)
  );

  always #5 clk = ~clk;

  // One SPI bit: low phase (mosi set, miso sampled at its end), then high phase.
  task automatic spi_bit(input logic b, output logic s);
    spi.sclk = 1'b0;
    spi.mosi = b;
    repeat (4) @(posedge clk);
    #1 s = miso;
    spi.sclk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic rw, input logic [3:0] addr, input logic [7:0] wd,
                           output logic [7:0] rd);
    logic [15:0] f;
    logic s;
    f = {rw, addr, 3'b000, wd};
    rd = '0;
    spi.ss = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 15; i >= 0; i--) begin
      spi_bit(f[i], s);
      if (i <= 7) rd[i] = s;
    end
    spi.ss = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input logic [3:0] addr, input logic [7:0] wd);
    logic [7:0] dummy;
    spi_frame(1'b0, addr, wd, dummy);
  endtask

  task automatic spi_read(input logic [3:0] addr, output logic [7:0] rd);
    spi_frame(1'b1, addr, 8'h00, rd);
  endtask

  // Quadrature reference: position in the forward cycle 00,01,11,10.
  function automatic int quad_step(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int ip = 0;
    int ic = 0;
    for (int k = 0; k < 4; k++) begin
      if (order[k] == p) ip = k;
      if (order[k] == c) ic = k;
    end
    if (ic == (ip + 1) % 4) return 1;
    if (ic == (ip + 3) % 4) return -1;
    return 0;
  endfunction

  task automatic set_tach(input int ch, input logic [1:0] v);
    tach_model[ch] = tach_model[ch] + 16'(quad_step(tach_pos[ch], v));
    tach_pos[ch] = v;
    case (ch)
      0:       tach0 = v;
      1:       tach1 = v;
      default: tach2 = v;
    endcase
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic read_tach(input int ch, output logic [15:0] val);
    logic [7:0] lo, hi;
    spi_read(4'(4 * ch), lo);
    spi_read(4'(4 * ch + 1), hi);
    val = {hi, lo};
  endtask

  task automatic measure(input int ch, output int fwd, output int rev);
    logic [1:0] p;
    fwd = 0;
    rev = 0;
    repeat (600) @(posedge clk);
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      p = (ch == 0) ? pwm0 : (ch == 1) ? pwm1 : pwm2;
      fwd += int'(p[0]);
      rev += int'(p[1]);
    end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    total++;
    if ({pwm2, pwm1, pwm0, motorena} !== 7'b0) begin
      $display("FAIL reset_outputs: got %b required 0", {pwm2, pwm1, pwm0, motorena});
    end else passed++;
    spi_read(4'hD, r);
    total++;
    if (r !== 8'h30) $display("FAIL hw_config: got %h required 30", r);
    else passed++;
    spi_read(4'hC, r);
    total++;
    if (r !== 8'h00) $display("FAIL addr_c: got %h required 00", r);
    else passed++;
    spi_read(4'hF, r);
    total++;
    if (r !== 8'h00) $display("FAIL reset_ctrl: got %h required 00", r);
    else passed++;
    spi_read(4'h2, r);
    total++;
    if (r !== 8'h00) $display("FAIL reset_cfg0: got %h required 00", r);
    else passed++;
  endtask

  task automatic test_config();
    logic [7:0] r, d;
    int ch;
    spi_write(4'h2, 8'h01);
    spi_write(4'h6, 8'h02);
    spi_write(4'hA, 8'h04);
    cfg_model = '{8'h01, 8'h02, 8'h04};
    for (int c = 0; c < 3; c++) begin
      spi_read(4'(4 * c + 2), r);
      total++;
      if (r !== cfg_model[c]) $display("FAIL cfg%0d: got %h required %h", c, r, cfg_model[c]);
      else passed++;
    end
    repeat (5) begin
      ch = $urandom_range(0, 2);
      d  = 8'($urandom);
      spi_write(4'(4 * ch + 2), d);
      cfg_model[ch] = d;
    end
    for (int c = 0; c < 3; c++) begin
      spi_read(4'(4 * c + 2), r);
      total++;
      if (r !== cfg_model[c]) $display("FAIL cfg_rand%0d: got %h required %h", c, r, cfg_model[c]);
      else passed++;
    end
    d = 8'($urandom);
    spi_write(4'hE, d);
    spi_read(4'hE, r);
    total++;
    if (r !== d) $display("FAIL wdiv_rw: got %h required %h", r, d);
    else passed++;
  endtask

  // 17 ticks of 16 clocks = 272 clocks to trip after the last write.
  task automatic test_watchdog();
    logic [7:0] r;
    wdogdisn = 1'b1;
    tstn = 1'b0;
    spi_write(4'hE, 8'h10);
    spi_write(4'hF, 8'h0F);
    repeat (200) @(posedge clk);
    #1;
    total++;
    if (motorena !== 1'b1) $display("FAIL wd_early: motorena got %b required 1", motorena);
    else passed++;
    repeat (1050) @(posedge clk);
    #1;
    total++;
    if (motorena !== 1'b0) $display("FAIL wd_trip_motorena: got %b required 0", motorena);
    else passed++;
    spi_read(4'hF, r);
    total++;
    if (r !== 8'h8F) $display("FAIL wd_trip_flag: got %h required 8f", r);
    else passed++;
    spi_write(4'hF, 8'h80);
    spi_read(4'hF, r);
    total++;
    if (r !== 8'h00) $display("FAIL wd_w1c: got %h required 00", r);
    else passed++;
    spi_write(4'hF, 8'h0F);
    spi_read(4'hF, r);
    total++;
    if (r !== 8'h0F) $display("FAIL wd_rearm: got %h required 0f", r);
    else passed++;
    wdogdisn = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    total++;
    if (motorena !== 1'b1) $display("FAIL wd_disabled: motorena got %b required 1", motorena);
    else passed++;
  endtask

  task automatic test_tach();
    logic [1:0]  seq [5] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
    logic [15:0] expv [5] = '{16'h0001, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF};
    logic [15:0] v;
    int ch;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 5; k++) begin
        set_tach(c, seq[k]);
        read_tach(c, v);
        total++;
        if (v !== expv[k]) $display("FAIL tach%0d_step%0d: got %h required %h", c, k, v, expv[k]);
        else passed++;
      end
    end
    repeat (12) begin
      ch = $urandom_range(0, 2);
      set_tach(ch, 2'($urandom));
      set_tach(ch, 2'($urandom));
      read_tach(ch, v);
      total++;
      if (v !== tach_model[ch]) begin
        $display("FAIL tach%0d_rand: got %h required %h", ch, v, tach_model[ch]);
      end else passed++;
    end
  endtask

  task automatic pwm_case(input int ch, input logic [7:0] duty, input logic dir,
                          input logic [3:0] ctrl);
    int fwd, rev, act, efwd, erev;
    spi_write(4'(4 * ch), duty);
    spi_write(4'(4 * ch + 2), {7'($urandom), dir});
    spi_write(4'hF, {4'h0, ctrl});
    act  = (ctrl[3] && ctrl[ch]) ? int'(duty) : 0;
    efwd = dir ? 0 : act;
    erev = dir ? act : 0;
    measure(ch, fwd, rev);
    total++;
    if (fwd !== efwd) $display("FAIL pwm%0d_fwd duty=%h: got %0d required %0d", ch, duty, fwd, efwd);
    else passed++;
    total++;
    if (rev !== erev) $display("FAIL pwm%0d_rev duty=%h: got %0d required %0d", ch, duty, rev, erev);
    else passed++;
    total++;
    if (motorena !== ctrl[3]) $display("FAIL pwm_motorena: got %b required %b", motorena, ctrl[3]);
    else passed++;
  endtask

  task automatic test_pwm();
    logic [7:0] r;
    int fwd, rev;
    wdogdisn = 1'b0;
    pwm_case(0, 8'h40, 1'b0, 4'hF);
    pwm_case(0, 8'hC0, 1'b0, 4'hF);
    pwm_case(0, 8'h80, 1'b0, 4'hF);
    pwm_case(0, 8'h80, 1'b1, 4'hF);
    pwm_case($urandom_range(0, 2), 8'h00, 1'($urandom), 4'hF);
    pwm_case($urandom_range(0, 2), 8'hFF, 1'($urandom), 4'hF);
    repeat (3) pwm_case($urandom_range(0, 2), 8'($urandom), 1'($urandom), 4'hF);
    pwm_case(0, 8'h80, 1'b0, 4'hE);
    pwm_case(2, 8'h80, 1'b0, 4'h7);
    // Over-current on channel 1.
    pwm_case(1, 8'h80, 1'b0, 4'hF);
    currentlimit1 = 1'b1;
    spi_read(4'h7, r);
`ifdef CURRENT_LIMIT_EN
    total++;
    if (r !== 8'h01) $display("FAIL climit_status: got %h required 01", r);
    else passed++;
`else
    total++;
    if (r !== 8'h00) $display("FAIL climit_status: got %h required 00", r);
    else passed++;
    measure(1, fwd, rev);
    total++;
    if (fwd !== 128) $display("FAIL climit_ignored: got %0d required 128", fwd);
    else passed++;
`endif
    currentlimit1 = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] f;
    logic [7:0] r;
    logic s;
    spi_write(4'h2, 8'h5A);
    f = {1'b0, 4'h2, 3'b000, 8'hA5};
    for (int i = 15; i >= 0; i--) spi_bit(f[i], s);
    spi_read(4'h2, r);
    total++;
    if (r !== 8'h5A) $display("FAIL abort_ss_low: got %h required 5a", r);
    else passed++;
    spi.ss = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 15; i >= 6; i--) spi_bit(f[i], s);
    spi.ss = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    spi_read(4'h2, r);
    total++;
    if (r !== 8'h5A) $display("FAIL abort_10bit: got %h required 5a", r);
    else passed++;
    spi_write(4'h2, 8'h3C);
    spi_read(4'h2, r);
    total++;
    if (r !== 8'h3C) $display("FAIL after_abort: got %h required 3c", r);
    else passed++;
  endtask

  initial begin
    rst_n         = 1'b0;
    spi.ss        = 1'b0;
    spi.sclk      = 1'b1;
    spi.mosi      = 1'b0;
    tstn          = 1'b1;
    wdogdisn      = 1'b1;
    currentlimit0 = 1'b0;
    currentlimit1 = 1'b0;
    currentlimit2 = 1'b0;
    tach0         = 2'b00;
    tach1         = 2'b00;
    tach2         = 2'b00;
    tach_model    = '{default: 16'h0000};
    tach_pos      = '{default: 2'b00};
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_config();
    test_watchdog();
    test_tach();
    test_pwm();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
